// File: rtl/btn_event_classifier.sv
// Classifies debounced active-low button gestures into short, long and double
// presses; emits one-cycle event pulses and a wrapping event counter.
module btn_event_classifier #(
  parameter int CLK_FREQ      = 50_000_000,
  parameter int LONG_PRESS_MS = 1000,
  parameter int DOUBLE_GAP_MS = 300
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_db_i,
  output logic       pressed_o,
  output logic       short_o,
  output logic       long_o,
  output logic       double_o,
  output logic [7:0] evt_cnt_o
);

  localparam int LONG_CYC = CLK_FREQ / 1000 * LONG_PRESS_MS;
  localparam int GAP_CYC  = CLK_FREQ / 1000 * DOUBLE_GAP_MS;
  localparam int MAX_CYC  = (LONG_CYC > GAP_CYC) ? LONG_CYC : GAP_CYC;
  localparam int CNT_W    = $clog2(MAX_CYC) + 1;

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYC - 1);

  generate
    if (LONG_CYC < 2 || GAP_CYC < 2) begin : g_bad_cfg
      $error("btn_event_classifier: LONG_CYC and GAP_CYC must both be >= 2");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_ARM,
    S_IDLE,
    S_PRESS1,
    S_LONG_HELD,
    S_WAIT_GAP,
    S_PRESS2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_short_next;
  logic             w_long_next;
  logic             w_double_next;
  logic             w_evt;

  logic             r_pressed;
  logic             r_short;
  logic             r_long;
  logic             r_double;
  logic [7:0]       r_evt_cnt;

  always_comb begin
    w_state_next  = r_state;
    w_cnt_next    = r_cnt;
    w_short_next  = 1'b0;
    w_long_next   = 1'b0;
    w_double_next = 1'b0;
    case (r_state)
      // ARM swallows a press that was already held when reset released.
      S_ARM: begin
        if (btn_db_i) w_state_next = S_IDLE;
      end
      S_IDLE: begin
        if (!btn_db_i) begin
          w_state_next = S_PRESS1;
          w_cnt_next   = '0;
        end
      end
      S_PRESS1: begin
        if (btn_db_i) begin
          w_state_next = S_WAIT_GAP;
          w_cnt_next   = '0;
        end else if (r_cnt == LONG_LAST) begin
          w_long_next  = 1'b1;
          w_state_next = S_LONG_HELD;
        end else begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end
      S_LONG_HELD: begin
        if (btn_db_i) w_state_next = S_IDLE;
      end
      // A press on the timeout edge itself still counts as a double.
      S_WAIT_GAP: begin
        if (!btn_db_i) begin
          w_double_next = 1'b1;
          w_state_next  = S_PRESS2;
        end else if (r_cnt == GAP_LAST) begin
          w_short_next = 1'b1;
          w_state_next = S_IDLE;
        end else begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end
      S_PRESS2: begin
        if (btn_db_i) w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_ARM;
      end
    endcase
  end

  assign w_evt = w_short_next | w_long_next | w_double_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_ARM;
      r_cnt     <= '0;
      r_pressed <= 1'b0;
      r_short   <= 1'b0;
      r_long    <= 1'b0;
      r_double  <= 1'b0;
      r_evt_cnt <= 8'd0;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_pressed <= ~btn_db_i;
      r_short   <= w_short_next;
      r_long    <= w_long_next;
      r_double  <= w_double_next;
      if (w_evt) r_evt_cnt <= r_evt_cnt + 8'd1;
    end
  end

  assign pressed_o = r_pressed;
  assign short_o   = r_short;
  assign long_o    = r_long;
  assign double_o  = r_double;
  assign evt_cnt_o = r_evt_cnt;

endmodule

// File: doc/btn_event_classifier.md
Name: btn_event_classifier

Overview:
Downstream of the LED/button debounce stage. Consumes the debounced, active-low button level and classifies each gesture as a short press, long press or double press. Emits one-cycle event pulses and a wrapping event counter for LED mode/pattern logic. Single clock domain; the input is already synchronous and glitch-free.

Parameters:
CLK_FREQ, 50_000_000, clock frequency in Hz
LONG_PRESS_MS, 1000, hold time in ms that makes a press "long"
DOUBLE_GAP_MS, 300, maximum release-to-second-press gap in ms for a double press
Derived: LONG_CYC = CLK_FREQ/1000*LONG_PRESS_MS; GAP_CYC = CLK_FREQ/1000*DOUBLE_GAP_MS. Both must be >= 2; elaboration error otherwise.
Counter width: $clog2(max(LONG_CYC, GAP_CYC)) + 1.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous reset, active-high
btn_db_i  input  1  debounced button level; 1 = released, 0 = pressed
pressed_o  output  1  registered ~btn_db_i (1-cycle latency)
short_o  output  1  one-cycle pulse: single short press
long_o  output  1  one-cycle pulse: press held LONG_CYC cycles
double_o  output  1  one-cycle pulse: second press within gap
evt_cnt_o  output  8  count of all event pulses; wraps 255 -> 0

Behaviour:
- Reset (rst=1 at a clock edge): state=ARM, cnt=0, every output 0, evt_cnt_o=0. Reset wins over all other activity, including mid-gesture; no pulse is emitted for an aborted gesture.
- The FSM samples btn_db_i at each edge. All outputs are registered.
- ARM: wait for btn_db_i=1, then go to IDLE. A button held through reset therefore generates no event until it is released and pressed again.
- IDLE: btn_db_i=0 -> PRESS1, cnt=0.
- PRESS1, btn still 0: cnt++.
  - When cnt reaches LONG_CYC-1: long_o=1 for the next cycle, go to LONG_HELD.
  - Net effect: long_o rises exactly LONG_CYC edges after the edge that first sampled 0.
- PRESS1, btn=1 before the long threshold: go to WAIT_GAP, cnt=0.
- LONG_HELD: stay until btn=1, then IDLE. No further pulses, regardless of hold length.
- WAIT_GAP, btn=1: cnt++.
  - When cnt reaches GAP_CYC-1: short_o pulse, go to IDLE.
  - short_o rises GAP_CYC edges after the release edge.
- WAIT_GAP, btn=0 (before timeout): double_o pulse on the next cycle, go to PRESS2.
  - A press sampled on the same edge where cnt=GAP_CYC-1 counts as a double, not a short: press has priority.
- PRESS2: wait for btn=1, then IDLE. Holding the second press never produces long_o.
- Only one event pulse per gesture. short_o, long_o and double_o are mutually exclusive in any cycle.
- evt_cnt_o increments on the same edge that asserts any event pulse. Modulo-256.
- pressed_o is independent of the FSM, including in ARM. It is 0 in the first cycle after reset.

Test Plan:
Use CLK_FREQ=10_000, LONG_PRESS_MS=10, DOUBLE_GAP_MS=3, giving LONG_CYC=100 and GAP_CYC=30.
1. Hold btn 0 for 20 cycles, then release -> exactly one short_o, 30 cycles after the release edge; long_o=double_o=0; evt_cnt_o=1.
2. Hold btn 0 for 250 cycles -> long_o pulses once, 100 edges after the first low sample; no pulse on release; evt_cnt_o=1.
3. Press 10, release 15, press 10, release -> double_o 1 cycle after the second press; no short_o; evt_cnt_o=1. Repeat with gap=29 (double) and gap=31 (short followed by a new press1 gesture).
4. Hold btn 0 across reset, deassert rst, keep low 300 cycles, then release -> no events. Next 20-cycle press -> short_o.
5. Assert rst during WAIT_GAP (cnt=15) -> outputs stay 0, no short_o after reset. Assert rst in PRESS1 at cnt=99 -> no long_o.
6. Issue 257 short presses back-to-back -> evt_cnt_o sequence 1..255, 0, 1. Check pressed_o tracks ~btn_db_i with 1-cycle lag throughout.
